// File: rtl/hazard_control.sv
// Front-end pipeline sequencer: load-use stall insertion, branch squash,
// debug halt/single-step and a saturating stall-cycle counter.
module hazard_control #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned STALL_CNT_W       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_reg_dest,
    input  logic                   branch_taken,
    input  logic                   halt_req,
    input  logic                   step_req,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int unsigned REM_W    = 4;
    localparam logic        MULTI    = (LOAD_STALL_CYCLES > 1);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;
    typedef enum logic [1:0] {M_ADVANCE, M_SQUASH, M_BUBBLE, M_HOLD} mode_t;

    state_t                 state_q, state_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    mode_t                  mode, eval_mode;
    logic                   load_use;

    assign load_use = ex_mem_read && (ex_reg_dest != 5'd0) &&
                      ((ex_reg_dest == id_rs) || (id_uses_rt && (ex_reg_dest == id_rt)));

    // Result of an "evaluating" cycle: branch beats load-use beats normal flow.
    always_comb begin
        eval_mode = M_ADVANCE;
        if (branch_taken) begin
            eval_mode = M_SQUASH;
        end else if (load_use) begin
            eval_mode = M_BUBBLE;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode    = M_ADVANCE;
        case (state_q)
            S_RUN: begin
                if (halt_req && !branch_taken && !load_use) begin
                    mode    = M_HOLD;
                    state_d = S_HALT;
                end else begin
                    mode = eval_mode;
                    if (eval_mode == M_BUBBLE && MULTI) begin
                        rem_d   = REM_LOAD;
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (branch_taken) begin
                    mode    = M_SQUASH;
                    rem_d   = '0;
                    state_d = S_RUN;
                end else begin
                    mode  = M_BUBBLE;
                    rem_d = rem_q - REM_W'(1);
                    // rem of 0 is unreachable; treat it as the last bubble
                    if (rem_q <= REM_W'(1)) begin
                        rem_d   = '0;
                        state_d = halt_req ? S_HALT : S_RUN;
                    end
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    mode    = M_HOLD;
                    state_d = S_RUN;
                end else if (step_req) begin
                    mode = eval_mode;
                    if (eval_mode == M_BUBBLE && MULTI) begin
                        rem_d   = REM_LOAD;
                        state_d = S_STALL;
                    end
                end else begin
                    mode = M_HOLD;
                end
            end
            default: begin
                state_d = S_RUN;
                rem_d   = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mode == M_BUBBLE && cnt_q != {STALL_CNT_W{1'b1}}) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_write    = (mode == M_ADVANCE) || (mode == M_SQUASH);
    assign if_id_write = (mode == M_ADVANCE) || (mode == M_SQUASH);
    assign if_id_flush = (mode == M_SQUASH);
    assign id_ex_flush = (mode != M_ADVANCE);
    assign halted      = (state_q == S_HALT);
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: two instances (1 and 3 bubbles per
// load-use) share stimulus; expectations are queued per cycle and popped on the falling edge.
module tb_hazard_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_reg_dest;
    logic        id_uses_rt, ex_mem_read, branch_taken, halt_req, step_req;

    logic        pcw1, ifw1, iff1, idf1, hlt1;
    logic [15:0] cnt1;
    logic        pcw3, ifw3, iff3, idf3, hlt3;
    logic [15:0] cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush}
    localparam logic [3:0] ADV = 4'b1100;
    localparam logic [3:0] SQ  = 4'b1111;
    localparam logic [3:0] BUB = 4'b0001;
    localparam logic [3:0] HLD = 4'b0001;

    typedef struct {
        string       tag;
        logic [20:0] e1;
        logic [20:0] e3;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    hazard_control #(.LOAD_STALL_CYCLES(1), .STALL_CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_reg_dest(ex_reg_dest),
        .branch_taken(branch_taken), .halt_req(halt_req), .step_req(step_req),
        .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(iff1), .id_ex_flush(idf1),
        .halted(hlt1), .stall_count(cnt1)
    );

    hazard_control #(.LOAD_STALL_CYCLES(3), .STALL_CNT_W(16)) dut3 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_reg_dest(ex_reg_dest),
        .branch_taken(branch_taken), .halt_req(halt_req), .step_req(step_req),
        .pc_write(pcw3), .if_id_write(ifw3), .if_id_flush(iff3), .id_ex_flush(idf3),
        .halted(hlt3), .stall_count(cnt3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ex(input logic h, input logic [3:0] set, input logic [15:0] cnt);
        return {h, set, cnt};
    endfunction

    // Inputs are already applied; queue this cycle's expectation and advance one clock.
    task automatic tick(input string tag, input logic [20:0] e1, input logic [20:0] e3);
        exp_t e;
        e.tag = tag;
        e.e1  = e1;
        e.e3  = e3;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic tick_nochk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_hazard(input logic on);
        ex_mem_read = on;
        ex_reg_dest = 5'd8;
        id_rs       = 5'd8;
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq({e.tag, "/lsc1"}, 32'({hlt1, pcw1, ifw1, iff1, idf1, cnt1}), 32'(e.e1));
            check_eq({e.tag, "/lsc3"}, 32'({hlt3, pcw3, ifw3, iff3, idf3, cnt3}), 32'(e.e3));
        end
    end

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; ex_reg_dest = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
        halt_req = 1'b0; step_req = 1'b0;
        tick_nochk(2);
        tick("reset", ex(0, ADV, 0), ex(0, ADV, 0));
        reset = 1'b0;

        // load-use on rs: 1 bubble vs 3 bubbles
        set_hazard(1'b1);
        tick("lu_a", ex(0, BUB, 0), ex(0, BUB, 0));
        ex_mem_read = 1'b0;
        tick("lu_b", ex(0, ADV, 1), ex(0, BUB, 1));
        tick("lu_c", ex(0, ADV, 1), ex(0, BUB, 2));
        tick("lu_d", ex(0, ADV, 1), ex(0, ADV, 3));

        // no hazard on r0 or on an unused rt; hazard once rt is used
        ex_mem_read = 1'b1; ex_reg_dest = 5'd0; id_rs = 5'd0;
        tick("r0", ex(0, ADV, 1), ex(0, ADV, 3));
        ex_reg_dest = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        tick("rt_unused", ex(0, ADV, 1), ex(0, ADV, 3));
        id_uses_rt = 1'b1;
        tick("rt_used", ex(0, BUB, 1), ex(0, BUB, 3));
        ex_mem_read = 1'b0; id_uses_rt = 1'b0;
        tick("rt_b", ex(0, ADV, 2), ex(0, BUB, 4));
        tick("rt_c", ex(0, ADV, 2), ex(0, BUB, 5));
        tick("rt_d", ex(0, ADV, 2), ex(0, ADV, 6));

        // branch wins over a simultaneous load-use
        set_hazard(1'b1); branch_taken = 1'b1;
        tick("br_lu", ex(0, SQ, 2), ex(0, SQ, 6));
        set_hazard(1'b0); branch_taken = 1'b0;
        tick("br_after", ex(0, ADV, 2), ex(0, ADV, 6));

        // halt, single step, resume
        halt_req = 1'b1;
        tick("halt_enter", ex(0, HLD, 2), ex(0, HLD, 6));
        tick("halt_hold", ex(1, HLD, 2), ex(1, HLD, 6));
        step_req = 1'b1;
        tick("step", ex(1, ADV, 2), ex(1, ADV, 6));
        step_req = 1'b0;
        tick("step_after", ex(1, HLD, 2), ex(1, HLD, 6));
        halt_req = 1'b0;
        tick("resume_hold", ex(1, HLD, 2), ex(1, HLD, 6));
        tick("resume_run", ex(0, ADV, 2), ex(0, ADV, 6));

        // halt raised in the 2nd bubble: the stall still completes
        set_hazard(1'b1);
        tick("hs_a", ex(0, BUB, 2), ex(0, BUB, 6));
        ex_mem_read = 1'b0; halt_req = 1'b1;
        tick("hs_b", ex(0, HLD, 3), ex(0, BUB, 7));
        tick("hs_c", ex(1, HLD, 3), ex(0, BUB, 8));
        tick("hs_d", ex(1, HLD, 3), ex(1, HLD, 9));

        // single step that hits a load-use, STALL returns to HALT
        set_hazard(1'b1); step_req = 1'b1;
        tick("sl_a", ex(1, BUB, 3), ex(1, BUB, 9));
        ex_mem_read = 1'b0; step_req = 1'b0;
        tick("sl_b", ex(1, HLD, 4), ex(0, BUB, 10));
        tick("sl_c", ex(1, HLD, 4), ex(0, BUB, 11));
        tick("sl_d", ex(1, HLD, 4), ex(1, HLD, 12));
        halt_req = 1'b0;
        tick("sl_res", ex(1, HLD, 4), ex(1, HLD, 12));
        tick("sl_run", ex(0, ADV, 4), ex(0, ADV, 12));

        // reset in the middle of a stall
        set_hazard(1'b1);
        tick("rs_a", ex(0, BUB, 4), ex(0, BUB, 12));
        set_hazard(1'b0); reset = 1'b1;
        tick_nochk(1);
        reset = 1'b0;
        tick("rs_after", ex(0, ADV, 0), ex(0, ADV, 0));

        // saturation: continuous load-use for more than 2^16 cycles
        set_hazard(1'b1);
        tick_nochk(65540);
        tick("sat_a", ex(0, BUB, 16'hFFFF), ex(0, BUB, 16'hFFFF));
        tick("sat_b", ex(0, BUB, 16'hFFFF), ex(0, BUB, 16'hFFFF));
        set_hazard(1'b0);
        tick_nochk(3);
        tick("sat_hold", ex(0, ADV, 16'hFFFF), ex(0, ADV, 16'hFFFF));

        @(posedge clock);
        #1;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline sequencer for the IF/ID/EX front end. It drives the PC and IF/ID write enables and the IF/ID and ID/EX flush controls.
- Detects load-use hazards between the instruction in decode and a load in execute. Inserts LOAD_STALL_CYCLES bubbles for each one.
- Squashes wrong-path instructions on a taken branch/jump resolved in EX.
- Provides a debug halt/single-step mechanism and a saturating stall-cycle counter.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15.
- STALL_CNT_W, 16, width of stall_count.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs  input  5  decode-stage source register (instruction[25:21]).
- id_rt  input  5  decode-stage second source register (instruction[20:16]).
- id_uses_rt  input  1  decode instruction reads rt (R-type, store, branch).
- ex_mem_read  input  1  instruction in EX is a load.
- ex_reg_dest  input  5  destination register of the instruction in EX.
- branch_taken  input  1  branch/jump in EX resolved taken; PC loads jump_dest_addr this cycle.
- halt_req  input  1  debug halt request, level-sensitive.
- step_req  input  1  single-cycle pulse; advances one cycle while halted.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID loads NOP.
- id_ex_flush  output  1  ID/EX loads bubble (all control zero).
- halted  output  1  state is HALT.
- stall_count  output  STALL_CNT_W  cycles in which pc_write=0 outside HALT-hold; saturating.

Behaviour:
- Hazard term (combinational): load_use = ex_mem_read & (ex_reg_dest!=0) & ((ex_reg_dest==id_rs) | (id_uses_rt & ex_reg_dest==id_rt)).
- State register: RUN, STALL, HALT. Remaining-bubble counter rem is 4 bits.
- Reset: state=RUN, rem=0, stall_count=0, halted=0. Reset overrides every other input in the same edge.
- Outputs are combinational from state and current inputs. Zero-latency control is required because the enables act on the same edge.
- Output sets:
  - ADVANCE: pc_write=1, if_id_write=1, flushes=0.
  - SQUASH: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1.
  - BUBBLE: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
  - HOLD: same values as BUBBLE, but not counted in stall_count.
- Priority in any cycle that "evaluates": branch_taken > load_use > normal.
  - branch_taken: SQUASH.
  - load_use: BUBBLE. If LOAD_STALL_CYCLES>1, then rem<=LOAD_STALL_CYCLES-1 and next=STALL.
  - Otherwise the cycle uses ADVANCE.
- RUN:
  - If halt_req=1 and neither branch_taken nor load_use is active: HOLD this cycle, next=HALT.
  - Otherwise evaluate normally and stay in RUN, unless a load-use moves to STALL.
- STALL:
  - Emit BUBBLE and decrement rem.
  - When rem==1, next = HALT if halt_req else RUN.
  - A branch_taken in STALL (cannot occur under legal operation, since EX holds a bubble) forces SQUASH and next=RUN, clearing rem.
- HALT: halted=1.
  - halt_req=0: HOLD this cycle, next=RUN. Any step_req in the same cycle is ignored.
  - halt_req=1 and step_req=1: evaluate this cycle as one RUN cycle, and next=HALT.
    - If the step hits load_use, the step produces BUBBLE and the step is consumed.
    - If LOAD_STALL_CYCLES>1 in that case, next=STALL; STALL then returns to HALT.
  - Otherwise: HOLD.
- stall_count: increments by 1 on each BUBBLE cycle. It saturates at all-ones and never wraps. SQUASH and HOLD do not count.
- halted is registered, i.e. it reflects the state register, not the next state.

Test Plan:
- Load-use hazard, LOAD_STALL_CYCLES=1: ex_mem_read=1, ex_reg_dest=8, id_rs=8 for one cycle, then a bubble arrives in EX. Required: exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1; state stays RUN.
- Multi-cycle stall, LOAD_STALL_CYCLES=3:
  - Same hazard, with ex_mem_read dropped after the first cycle. Required: 3 consecutive BUBBLE cycles, then ADVANCE; stall_count=3.
  - Second case: ex_reg_dest=0, or id_rt match with id_uses_rt=0. Required: no stall.
- Branch beats hazard: branch_taken=1 and load_use both true in the same cycle. Required: SQUASH (pc_write=1, both flushes=1); stall_count unchanged; no STALL entry.
- Halt/step/resume:
  - Raise halt_req with no hazards. Required: HOLD; halted=1 from the next cycle.
  - Pulse step_req for 1 cycle. Required: exactly one ADVANCE cycle, then HOLD.
  - Drop halt_req. Required: one HOLD cycle, then RUN with ADVANCE; halted=0.
- Halt during stall, LOAD_STALL_CYCLES=3: assert halt_req in the 2nd BUBBLE cycle. Required: the stall completes all 3 bubbles, then state=HALT; stall_count=3.
- Saturation and reset:
  - Preload via 65536+ BUBBLE cycles. Required: stall_count holds 16'hFFFF.
  - Assert reset mid-STALL. Required: next edge gives stall_count=0, state RUN, outputs ADVANCE.
